// File: rtl/sram_stream.sv
// sram_stream: on-node word memory with a burst read streamer.
// Writes load words by index; read requests stream {word, tag} flits over a
// valid/ready handshake with one-cycle latency. A burst ends on a programmed
// beat count, or (rd_len = 0) on the terminator word or after DEPTH beats.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data    word write port (any state)
//   rd_req/rd_addr/rd_len    read request (byte address, beat count)
//   rd_ready                 request accepted when rd_req && rd_ready
//   out_valid/out_ready      output flit handshake
//   out_flit                 {word, tag}, tag in [3:0]
//   busy                     burst in progress
//
// Build option: define SRAM_STREAM_WR_FWD_EN to forward a same-edge write
// into the flit being loaded; otherwise the old memory contents are loaded.
module sram_stream #(
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        DEPTH     = 128,
    parameter int unsigned        ADDR_W    = 7,
    parameter logic [3:0]         TAG_DATA  = 4'b0101,
    parameter logic [3:0]         TAG_LAST  = 4'b0110,
    parameter logic [DATA_W-1:0]  TERM_WORD = '1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_req,
    input  logic [31:0]         rd_addr,
    input  logic [ADDR_W:0]     rd_len,
    output logic                rd_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W+3:0]   out_flit,
    output logic                busy
);

    localparam int unsigned       LEN_W     = ADDR_W + 1;
    localparam logic [LEN_W-1:0]  DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [ADDR_W-1:0] BEAT_CAP  = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   beat;
    logic [LEN_W-1:0]    len;
    logic                last_q;

    logic                accept_c;
    logic [LEN_W-1:0]    req_len_c;
    logic [ADDR_W-1:0]   ld_idx_c;
    logic [ADDR_W-1:0]   ld_beat_c;
    logic [LEN_W-1:0]    ld_len_c;
    logic [DATA_W-1:0]   ld_word_c;
    logic                ld_last_c;
    logic                unused_rd_addr_c;

    // Only the word-index field of the byte address is meaningful.
    assign unused_rd_addr_c = ^{rd_addr[31:ADDR_W+4], rd_addr[3:0]};

    // Storage: 1R1W, never reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Next flit to load: first word on accept, else the following word.
    // The last-flit decision is made here so the tag is ready with the word.
    always_comb begin
        req_len_c = (rd_len > DEPTH_LEN) ? DEPTH_LEN : rd_len;
        accept_c  = rd_req && rd_ready;
        ld_idx_c  = accept_c ? rd_addr[ADDR_W+3:4] : ptr + ADDR_W'(1);
        ld_beat_c = accept_c ? '0 : beat + ADDR_W'(1);
        ld_len_c  = accept_c ? req_len_c : len;
        ld_word_c = mem[ld_idx_c];
`ifdef SRAM_STREAM_WR_FWD_EN
        if (wr_en && (wr_addr == ld_idx_c)) begin
            ld_word_c = wr_data;
        end
`endif
        if (ld_len_c != '0) begin
            ld_last_c = ({1'b0, ld_beat_c} == (ld_len_c - LEN_W'(1)));
        end else begin
            ld_last_c = (ld_word_c == TERM_WORD) || (ld_beat_c == BEAT_CAP);
        end
    end

    // Burst FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            beat      <= '0;
            len       <= '0;
            last_q    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            rd_ready  <= 1'b1;
            out_flit  <= {DATA_W'(0), 4'b0001};
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        ptr       <= ld_idx_c;
                        beat      <= ld_beat_c;
                        len       <= ld_len_c;
                        last_q    <= ld_last_c;
                        out_flit  <= {ld_word_c, ld_last_c ? TAG_LAST : TAG_DATA};
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        rd_ready  <= 1'b0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (last_q) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            rd_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            ptr      <= ld_idx_c;
                            beat     <= ld_beat_c;
                            last_q   <= ld_last_c;
                            out_flit <= {ld_word_c, ld_last_c ? TAG_LAST : TAG_DATA};
                        end
                    end
                end
            endcase
        end
    end

endmodule
